// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the opcode control decoder. Holds the
//   program counter and reads instruction words over a req/ack handshake. It
//   presents each fetched word to decode, then either advances sequentially or
//   follows a taken jump. A decoded halt stops fetching until the next reset.
//
//   Optional feature macro: FETCH_ACK_TIMEOUT_EN
//     When defined, an outstanding request that is not acknowledged within
//     ACK_TIMEOUT cycles raises a sticky o_memErr and halts the fetch stage.
//     When undefined, FETCH waits indefinitely and o_memErr is constant 0.
//
//   Parameters:
//     RESET_PC     PC value loaded on reset (word address)
//     ACK_TIMEOUT  request cycles allowed without ack (timeout build only)
//
//   Ports:
//     i_clk, i_rstn       clock, asynchronous active-low reset
//     o_memReq/o_memAddr  read request and word address (current PC)
//     i_memAck/i_memData  request accepted; instruction word valid same cycle
//     o_instrVld          o_instr/o_opcode/o_pc valid for decode
//     o_instr/o_opcode    held instruction word and its [15:12] opcode field
//     o_pc                address of the held instruction
//     i_stall             downstream not ready; hold the current instruction
//     i_isHLT             held instruction is a halt
//     i_jmpTaken/i_jmpAddr held instruction redirects the PC to i_jmpAddr
//     o_halted            fetch stopped (halt or memory error)
//     o_memErr            ack timeout occurred
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_memReq,
  output logic [15:0] o_memAddr,
  input  logic        i_memAck,
  input  logic [15:0] i_memData,
  output logic        o_instrVld,
  output logic [15:0] o_instr,
  output logic [3:0]  o_opcode,
  output logic [15:0] o_pc,
  input  logic        i_stall,
  input  logic        i_isHLT,
  input  logic        i_jmpTaken,
  input  logic [15:0] i_jmpAddr,
  output logic        o_halted,
  output logic        o_memErr
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_pc;
  logic [15:0] w_pcNext;
  logic [15:0] r_instr;
  logic [15:0] r_instrPc;
  logic        w_capture;

`ifdef FETCH_ACK_TIMEOUT_EN
  logic [7:0]  r_ackCnt;
  logic        r_memErr;
  logic        w_timeout;
`endif

  // Next-state and PC update. Halt has priority over a taken jump, and the
  // decode-side inputs only matter on the HOLD cycle that releases.
  always_comb begin
    w_nextState = r_state;
    w_pcNext    = r_pc;
    w_capture   = 1'b0;
`ifdef FETCH_ACK_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ST_RESET: w_nextState = ST_FETCH;
      ST_FETCH: begin
        if (i_memAck) begin
          w_capture   = 1'b1;
          w_nextState = ST_HOLD;
        end
`ifdef FETCH_ACK_TIMEOUT_EN
        // r_ackCnt counts the earlier unacknowledged cycles, so this is the
        // ACK_TIMEOUT-th request cycle without an ack.
        else if (r_ackCnt == ACK_TIMEOUT - 8'd1) begin
          w_timeout   = 1'b1;
          w_nextState = ST_HALT;
        end
`endif
      end
      ST_HOLD: begin
        if (!i_stall) begin
          if (i_isHLT) begin
            w_nextState = ST_HALT;
          end else begin
            w_nextState = ST_FETCH;
            // 16-bit add wraps FFFF -> 0000 by design.
            w_pcNext    = i_jmpTaken ? i_jmpAddr : r_pc + 16'd1;
          end
        end
      end
      ST_HALT:  w_nextState = ST_HALT;
      default:  w_nextState = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= ST_RESET;
      r_pc      <= RESET_PC;
      r_instr   <= 16'h0000;
      r_instrPc <= 16'h0000;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_pcNext;
      if (w_capture) begin
        r_instr   <= i_memData;
        r_instrPc <= r_pc;
      end
    end
  end

`ifdef FETCH_ACK_TIMEOUT_EN
  // Counter is held at zero outside FETCH, so it starts from zero on every
  // entry to FETCH.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ackCnt <= 8'd0;
      r_memErr <= 1'b0;
    end else begin
      if (r_state != ST_FETCH) begin
        r_ackCnt <= 8'd0;
      end else if (!i_memAck) begin
        r_ackCnt <= r_ackCnt + 8'd1;
      end
      if (w_timeout) begin
        r_memErr <= 1'b1;
      end
    end
  end

  assign o_memErr = r_memErr;
`else
  // ACK_TIMEOUT has no effect in this build; the term only keeps it referenced.
  assign o_memErr = 1'b0 & (|ACK_TIMEOUT);
`endif

  // Outputs decode directly from state, so an asynchronous reset drops the
  // request immediately.
  assign o_memReq   = (r_state == ST_FETCH);
  assign o_memAddr  = r_pc;
  assign o_instrVld = (r_state == ST_HOLD);
  assign o_instr    = r_instr;
  assign o_opcode   = r_instr[15:12];
  assign o_pc       = r_instrPc;
  assign o_halted   = (r_state == ST_HALT);

endmodule
